// File: rtl/rtc_servo_ctrl.sv
// PTP servo: turns one signed offset measurement per exchange into RTC commands,
// either a direct time step or a series of bounded phase slews followed by a frequency trim.
module rtc_servo_ctrl #(
  parameter logic [39:0] NOMINAL_PERIOD = 40'h8_0000_0000,
  parameter int          STEP_THRESH_NS = 1000,
  parameter int          MAX_SLEW_NS    = 100,
  parameter logic [31:0] ADJ_DELAY      = 32'd0,
  parameter int          STEP_COMP_NS   = 8,
  parameter int          FREQ_GAIN_SHL  = 16,
  parameter logic [39:0] MAX_FREQ_ADJ   = 40'h0_0100_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        meas_valid,
  input  logic [63:0] meas_offset_ns,
  output logic        meas_ready,
  input  logic [63:0] time_ptp_ns,
  input  logic        adj_ld_done,
  output logic        time_ld,
  output logic [71:0] time_reg_ns_in,
  output logic        period_ld,
  output logic [39:0] period_in,
  output logic        adj_ld,
  output logic [31:0] adj_ld_data,
  output logic [39:0] period_adj,
  output logic        busy,
  output logic [15:0] step_count,
  output logic [15:0] drop_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_STEP,
    S_SLEW,
    S_WAIT_LO,
    S_WAIT_HI,
    S_FREQ
  } state_t;

  localparam logic [63:0]        THRESH   = 64'(STEP_THRESH_NS);
  localparam logic [63:0]        COMP     = 64'(STEP_COMP_NS);
  localparam logic [63:0]        OFF_MIN  = {1'b1, 63'b0};
  localparam logic [63:0]        ABS_MAX  = {1'b0, {63{1'b1}}};
  localparam logic signed [63:0] SLEW_POS = 64'(MAX_SLEW_NS);
  localparam logic signed [63:0] SLEW_NEG = -SLEW_POS;
  localparam logic signed [47:0] FREQ_POS = {8'h00, MAX_FREQ_ADJ};
  localparam logic signed [47:0] FREQ_NEG = -FREQ_POS;

  state_t      state_q;
  logic [63:0] off_q;
  logic [63:0] resid_q;
  logic [39:0] integ_q;
  logic        meas_ready_q;
  logic        time_ld_q;
  logic [71:0] time_reg_q;
  logic        period_ld_q;
  logic [39:0] period_in_q;
  logic        adj_ld_q;
  logic [31:0] adj_ld_data_q;
  logic [39:0] period_adj_q;
  logic [15:0] step_count_q;
  logic [15:0] drop_count_q;

  logic [63:0]        off_abs;
  logic [63:0]        step_time;
  logic signed [63:0] chunk;
  logic [47:0]        freq_inc;
  logic [47:0]        freq_sum;
  logic [39:0]        integ_d;

  // The most-negative offset has no positive twin, so its magnitude pins at 2^63-1.
  always_comb begin
    off_abs = off_q;
    if (off_q == OFF_MIN) begin
      off_abs = ABS_MAX;
    end else if (off_q[63]) begin
      off_abs = -off_q;
    end

    step_time = time_ptp_ns + off_q + COMP;

    chunk = resid_q;
    if ($signed(resid_q) > SLEW_POS) begin
      chunk = SLEW_POS;
    end else if ($signed(resid_q) < SLEW_NEG) begin
      chunk = SLEW_NEG;
    end

    freq_inc = {{8{off_q[39]}}, off_q[39:0]} << FREQ_GAIN_SHL;
    freq_sum = {{8{integ_q[39]}}, integ_q} + freq_inc;
    integ_d  = freq_sum[39:0];
    if ($signed(freq_sum) > FREQ_POS) begin
      integ_d = FREQ_POS[39:0];
    end else if ($signed(freq_sum) < FREQ_NEG) begin
      integ_d = FREQ_NEG[39:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      off_q         <= '0;
      resid_q       <= '0;
      integ_q       <= '0;
      meas_ready_q  <= 1'b1;
      time_ld_q     <= 1'b0;
      time_reg_q    <= '0;
      period_ld_q   <= 1'b0;
      period_in_q   <= NOMINAL_PERIOD;
      adj_ld_q      <= 1'b0;
      adj_ld_data_q <= ADJ_DELAY;
      period_adj_q  <= '0;
      step_count_q  <= '0;
      drop_count_q  <= '0;
    end else begin
      time_ld_q   <= 1'b0;
      adj_ld_q    <= 1'b0;
      period_ld_q <= 1'b0;

      if (meas_valid && (state_q != S_IDLE) && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (meas_valid) begin
            off_q        <= meas_offset_ns;
            resid_q      <= meas_offset_ns;
            meas_ready_q <= 1'b0;
            state_q      <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (off_abs >= THRESH) begin
            state_q <= S_STEP;
          end else if (off_q == 64'd0) begin
            state_q <= S_FREQ;
          end else begin
            state_q <= S_SLEW;
          end
        end
        S_STEP: begin
          time_ld_q    <= 1'b1;
          time_reg_q   <= {step_time, 8'h00};
          step_count_q <= step_count_q + 16'd1;
          meas_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        // Only one precise adjustment may be outstanding in the RTC at a time.
        S_SLEW: begin
          if (adj_ld_done) begin
            adj_ld_q      <= 1'b1;
            period_adj_q  <= {chunk[7:0], 32'h0};
            adj_ld_data_q <= ADJ_DELAY;
            resid_q       <= resid_q - chunk;
            state_q       <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!adj_ld_done) begin
            state_q <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (adj_ld_done) begin
            state_q <= (resid_q != 64'd0) ? S_SLEW : S_FREQ;
          end
        end
        S_FREQ: begin
          integ_q      <= integ_d;
          period_ld_q  <= 1'b1;
          period_in_q  <= NOMINAL_PERIOD + integ_d;
          meas_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          meas_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign meas_ready     = meas_ready_q;
  assign busy           = ~meas_ready_q;
  assign time_ld        = time_ld_q;
  assign time_reg_ns_in = time_reg_q;
  assign period_ld      = period_ld_q;
  assign period_in      = period_in_q;
  assign adj_ld         = adj_ld_q;
  assign adj_ld_data    = adj_ld_data_q;
  assign period_adj     = period_adj_q;
  assign step_count     = step_count_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_rtc_servo_ctrl.sv
// Scoreboard bench for rtc_servo_ctrl with a small RTC model closing the slew loop.
module tb_rtc_servo_ctrl;

  localparam int          KIND_TIME   = 0;
  localparam int          KIND_ADJ    = 1;
  localparam int          KIND_PERIOD = 2;
  localparam logic [39:0] NOMINAL     = 40'h8_0000_0000;

  typedef struct {
    int          kind;
    logic [71:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        meas_valid;
  logic [63:0] meas_offset_ns;
  logic        meas_ready;
  logic [63:0] time_ptp_ns;
  logic        adj_ld_done;
  logic        time_ld;
  logic [71:0] time_reg_ns_in;
  logic        period_ld;
  logic [39:0] period_in;
  logic        adj_ld;
  logic [31:0] adj_ld_data;
  logic [39:0] period_adj;
  logic        busy;
  logic [15:0] step_count;
  logic [15:0] drop_count;

  logic [95:0] rtcT;
  logic [95:0] refT;
  logic [39:0] periodReg;
  logic [39:0] adjVal;
  logic        adjStage;
  logic        holdDoneLow;
  logic        useFixed;
  logic [63:0] fixedTime;

  exp_t        expQ[$];
  int          checkCount;
  int          passCount;
  logic        needCycle;
  logic        doneLowSeen;
  logic [95:0] diffSnap;

  rtc_servo_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .meas_valid     (meas_valid),
    .meas_offset_ns (meas_offset_ns),
    .meas_ready     (meas_ready),
    .time_ptp_ns    (time_ptp_ns),
    .adj_ld_done    (adj_ld_done),
    .time_ld        (time_ld),
    .time_reg_ns_in (time_reg_ns_in),
    .period_ld      (period_ld),
    .period_in      (period_in),
    .adj_ld         (adj_ld),
    .adj_ld_data    (adj_ld_data),
    .period_adj     (period_adj),
    .busy           (busy),
    .step_count     (step_count),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign time_ptp_ns = useFixed ? fixedTime : rtcT[95:32];

  // RTC model: a slew loaded on one edge is applied for one cycle on the next, with done low for that cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rtcT        <= '0;
      refT        <= '0;
      periodReg   <= NOMINAL;
      adjVal      <= '0;
      adjStage    <= 1'b0;
      adj_ld_done <= 1'b1;
    end else begin
      refT <= refT + {56'b0, NOMINAL};
      if (time_ld) begin
        rtcT <= {time_reg_ns_in, 24'h0};
      end else if (adjStage) begin
        rtcT <= rtcT + {56'b0, periodReg} + {{56{adjVal[39]}}, adjVal};
      end else begin
        rtcT <= rtcT + {56'b0, periodReg};
      end
      if (period_ld) periodReg <= period_in;
      adjStage <= adj_ld;
      if (adj_ld) adjVal <= period_adj;
      adj_ld_done <= !(adjStage || holdDoneLow);
    end
  end

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] expv);
    checkCount++;
    if (act === expv) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic pushExp(input int kind, input logic [71:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    expQ.push_back(e);
  endtask

  function automatic logic [71:0] adjExp(input logic [7:0] ns);
    return {32'h0, ns, 32'h0};
  endfunction

  task automatic popCheck(input int kind, input logic [71:0] act, input string name);
    exp_t e;
    if (expQ.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL %s: unexpected strobe with data %h, expected none", name, act);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind) begin
        checkCount++;
        $display("[TB] FAIL %s: strobe kind %0d, expected kind %0d", name, kind, e.kind);
      end else begin
        checkOutput(name, act, e.data);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (time_ld) popCheck(KIND_TIME, time_reg_ns_in, "time_ld");
        if (adj_ld) begin
          if (needCycle) checkOutput("doneCycle", {71'b0, doneLowSeen & adj_ld_done}, 72'd1);
          popCheck(KIND_ADJ, {adj_ld_data, period_adj}, "adj_ld");
          needCycle   = 1'b1;
          doneLowSeen = 1'b0;
        end
        if (period_ld) begin
          diffSnap  = rtcT - refT;
          needCycle = 1'b0;
          popCheck(KIND_PERIOD, {32'h0, period_in}, "period_ld");
        end
        if (!adj_ld_done) doneLowSeen = 1'b1;
      end else begin
        needCycle = 1'b0;
      end
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rst = 1'b1;
    expQ.delete();
    holdDoneLow = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [63:0] offset);
    int n = 0;
    @(negedge clk);
    while (!meas_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("readyReached", {71'b0, meas_ready}, 72'd1);
    @(posedge clk);
    #1;
    meas_offset_ns = offset;
    meas_valid     = 1'b1;
    @(posedge clk);
    #1 meas_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((expQ.size() != 0 || !meas_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "Idle"}, {71'b0, (n < 2000)}, 72'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    rst            = 1'b1;
    meas_valid     = 1'b0;
    meas_offset_ns = '0;
    holdDoneLow    = 1'b0;
    useFixed       = 1'b0;
    fixedTime      = '0;
    checkCount     = 0;
    passCount      = 0;
    needCycle      = 1'b0;
    doneLowSeen    = 1'b0;
    diffSnap       = '0;
    fork
      monitor();
    join_none

    // Reset state
    doReset();
    repeat (2) @(negedge clk);
    checkOutput("rstReady",     {71'b0, meas_ready}, 72'd1);
    checkOutput("rstBusy",      {71'b0, busy}, 72'd0);
    checkOutput("rstStrobes",   {69'b0, time_ld, adj_ld, period_ld}, 72'd0);
    checkOutput("rstPeriodIn",  {32'b0, period_in}, {32'b0, NOMINAL});
    checkOutput("rstPeriodAdj", {32'b0, period_adj}, 72'd0);
    checkOutput("rstAdjData",   {40'b0, adj_ld_data}, 72'd0);
    checkOutput("rstTimeReg",   time_reg_ns_in, 72'd0);
    checkOutput("rstCounters",  {40'b0, step_count, drop_count}, 72'd0);

    // Large positive offset steps the time
    useFixed  = 1'b1;
    fixedTime = 64'd1_000_000;
    pushExp(KIND_TIME, {64'd1_005_008, 8'h00});
    applyStimulus(64'd5000);
    waitIdle("step5000");
    checkOutput("stepCount1", {56'b0, step_count}, 72'd1);

    // Threshold boundaries and the most-negative offset all step
    pushExp(KIND_TIME, {64'd1_001_008, 8'h00});
    applyStimulus(64'd1000);
    waitIdle("stepPos1000");
    pushExp(KIND_TIME, {64'd999_008, 8'h00});
    applyStimulus(-64'sd1000);
    waitIdle("stepNeg1000");
    pushExp(KIND_TIME, {64'h8000_0000_000F_4248, 8'h00});
    applyStimulus(64'h8000_0000_0000_0000);
    waitIdle("stepMinNeg");
    checkOutput("stepCount4", {56'b0, step_count}, 72'd4);

    // +250 slews 100/100/50 then trims frequency; RTC ends 250 ns ahead
    doReset();
    useFixed = 1'b0;
    pushExp(KIND_ADJ, adjExp(8'd100));
    pushExp(KIND_ADJ, adjExp(8'd100));
    pushExp(KIND_ADJ, adjExp(8'd50));
    pushExp(KIND_PERIOD, {32'h0, 40'h8_00FA_0000});
    applyStimulus(64'd250);
    waitIdle("slew250");
    checkOutput("rtcAhead250", diffSnap[71:0], {40'd250, 32'd0});
    checkOutput("slewNoStep", {56'b0, step_count}, 72'd0);

    // Small negative offset
    doReset();
    pushExp(KIND_ADJ, {32'h0, 40'hE2_0000_0000});
    pushExp(KIND_PERIOD, {32'h0, 40'h7_FFE2_0000});
    applyStimulus(-64'sd30);
    waitIdle("slewNeg30");

    // Just below threshold: ten slews, integrator saturates, repeat leaves period unchanged
    doReset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 9; i++) pushExp(KIND_ADJ, adjExp(8'd100));
      pushExp(KIND_ADJ, adjExp(8'd99));
      pushExp(KIND_PERIOD, {32'h0, 40'h8_0100_0000});
      applyStimulus(64'd999);
      waitIdle("slew999");
    end
    checkOutput("satPeriodIn", {32'b0, period_in}, {32'b0, 40'h8_0100_0000});

    // Measurements arriving mid-sequence are dropped without disturbing it
    doReset();
    pushExp(KIND_ADJ, adjExp(8'd100));
    pushExp(KIND_ADJ, adjExp(8'd100));
    pushExp(KIND_ADJ, adjExp(8'd50));
    pushExp(KIND_PERIOD, {32'h0, 40'h8_00FA_0000});
    applyStimulus(64'd250);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      meas_offset_ns = 64'd5000;
      meas_valid     = 1'b1;
      @(posedge clk);
      #1 meas_valid = 1'b0;
    end
    waitIdle("dropSeq");
    checkOutput("dropCount3", {56'b0, drop_count}, 72'd3);

    // Stuck done holds the controller busy; async reset aborts it
    pushExp(KIND_ADJ, adjExp(8'd100));
    applyStimulus(64'd250);
    n = 0;
    while (!adj_ld && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("firstAdjSeen", {71'b0, adj_ld}, 72'd1);
    holdDoneLow = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("stuckBusy", {71'b0, busy}, 72'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abortReady",    {71'b0, meas_ready}, 72'd1);
    checkOutput("abortBusy",     {71'b0, busy}, 72'd0);
    checkOutput("abortStrobes",  {69'b0, time_ld, adj_ld, period_ld}, 72'd0);
    checkOutput("abortPeriod",   {32'b0, period_in}, {32'b0, NOMINAL});
    checkOutput("abortAdj",      {32'b0, period_adj}, 72'd0);
    checkOutput("abortCounters", {40'b0, step_count, drop_count}, 72'd0);
    expQ.delete();
    holdDoneLow = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("queueDrained", 72'(expQ.size()), 72'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rtc_servo_ctrl.md
Name: rtc_servo_ctrl

Overview:
- Servo controller on the command side of the hardware RTC's adjustment interface.
- Takes one signed offset measurement per PTP exchange (correction = master − local, in ns) and turns it into RTC commands:
  - a direct time step (time_ld), or
  - a series of single-cycle phase slews (adj_ld / period_adj), followed by an integral frequency correction (period_ld).
- Sits between the PTP offset-computation logic and the RTC instance.

Parameters:
- NOMINAL_PERIOD, 40'h8_0000_0000: nominal clk period. 39:32 ns, 31:0 ns fraction.
- STEP_THRESH_NS, 1000: if |offset| ≥ this value, step the time instead of slewing.
- MAX_SLEW_NS, 100: per-command slew magnitude limit in ns. Legal range 1..127.
- ADJ_DELAY, 32'd0: value driven on adj_ld_data (RTC countdown before the adjustment applies).
- STEP_COMP_NS, 8: ns added to a stepped time to cover the one-cycle load latency.
- FREQ_GAIN_SHL, 16: left shift applied to the offset (ns) to form the integrator increment (2^-32 ns units).
- MAX_FREQ_ADJ, 40'h0_0100_0000: symmetric saturation limit of the frequency integrator.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous reset, active-high.
- meas_valid, in, 1: offset measurement strobe.
- meas_offset_ns, in, 64: signed two's-complement correction in ns.
- meas_ready, out, 1: high only in IDLE.
- time_ptp_ns, in, 64: current RTC time in ns.
- adj_ld_done, in, 1: RTC reports no precise adjustment is pending.
- time_ld, out, 1: one-cycle strobe.
- time_reg_ns_in, out, 72: stepped time. 71:8 ns, 7:0 fraction.
- period_ld, out, 1: one-cycle strobe.
- period_in, out, 40: corrected period.
- adj_ld, out, 1: one-cycle strobe.
- adj_ld_data, out, 32: adjustment countdown.
- period_adj, out, 40: signed single-cycle period delta.
- busy, out, 1: equals ~meas_ready.
- step_count, out, 16: steps issued, wraps.
- drop_count, out, 16: measurements dropped while busy, saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - All strobes 0; busy 0; meas_ready 1.
  - time_reg_ns_in 0; period_adj 0; adj_ld_data ADJ_DELAY; period_in NOMINAL_PERIOD.
  - Counters 0; integrator integ (40b signed) 0; state IDLE.
  - A reset asserted mid-operation aborts the sequence; no strobe is emitted after rst rises.
- Timing: all outputs are registered; strobes are exactly one cycle wide.
- IDLE:
  - On meas_valid, latch off = meas_offset_ns and resid = off; go to DECIDE.
  - meas_valid in any other state is ignored and drop_count increments.
- DECIDE (1 cycle), branching on abs(off), computed in 64b:
  - abs(off) ≥ STEP_THRESH_NS → STEP.
  - off == 0 → FREQ.
  - otherwise → SLEW.
- STEP:
  - Drive time_ld = 1 with time_reg_ns_in = {time_ptp_ns + off + STEP_COMP_NS, 8'h00}. Addition is modulo 2^64.
  - Increment step_count and return to IDLE.
  - integ is unchanged and no period_ld is issued.
- SLEW:
  - Wait while adj_ld_done == 0.
  - Then compute chunk = clamp(resid, −MAX_SLEW_NS, +MAX_SLEW_NS).
  - Drive adj_ld = 1, period_adj = {chunk[7:0], 32'h0}, adj_ld_data = ADJ_DELAY.
  - Update resid ← resid − chunk and go to WAIT_LO.
- WAIT_LO: wait for adj_ld_done == 0, then go to WAIT_HI.
  - The RTC drops done for at least one cycle, two edges after the load.
- WAIT_HI: wait for adj_ld_done == 1.
  - resid ≠ 0 → SLEW.
  - resid == 0 → FREQ.
- FREQ:
  - integ ← sat(integ + (sext40(off) << FREQ_GAIN_SHL), ±MAX_FREQ_ADJ).
  - Perform the add in 48b before saturating.
  - Drive period_ld = 1 with period_in = NOMINAL_PERIOD + the new integ. The value is computed combinationally from the new integ in the same cycle.
  - Return to IDLE.
- Boundaries:
  - off = ±STEP_THRESH_NS exactly takes the STEP path.
  - off = STEP_THRESH_NS − 1 takes the SLEW path.
  - Most-negative 64b offset: abs saturates to 2^63−1 and takes the STEP path.
  - meas_valid in the same cycle the controller returns to IDLE is dropped (meas_ready is still 0 in that cycle).
  - No timeout: a stuck adj_ld_done holds the controller in WAIT and asserts busy.

Test Plan:
1. Reset, then idle → meas_ready=1, period_in=40'h8_0000_0000, all strobes 0, counters 0.
2. time_ptp_ns=1_000_000, offset=+5000 → one time_ld with time_reg_ns_in[71:8]=1_005_008 and [7:0]=0; step_count=1; no adj_ld and no period_ld.
3. offset=+250 (RTC model in loop) → adj_ld pulses with period_adj[39:32]=100, 100, 50, each issued only after a done low→high cycle; then period_ld with period_in=40'h8_00FA_0000; RTC time ends 250 ns ahead of the free-run reference.
4. After reset, offset=−30 → one adj_ld with period_adj=40'hE2_0000_0000; period_in=40'h7_FFE2_0000.
5. offset=+999 → 10 slews (nine of +100 and one of +99); integ saturates, so period_in=40'h8_0100_0000; a second +999 leaves period_in unchanged.
6. Three meas_valid pulses during a slew sequence → drop_count=3, state sequence unaffected; rst asserted during WAIT_HI → all outputs return to reset values immediately.
